// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs drained one entry per cycle
// onto a single registered CDB using round-robin priority after the last grant.
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [4*NUM_SRC-1:0]    src_rob_pos,
    input  logic [32*NUM_SRC-1:0]   src_val,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic                    cdb_valid,
    output logic [3:0]              cdb_rob_pos,
    output logic [31:0]             cdb_val,
    output logic [1:0]              cdb_src,
    output logic                    overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [35:0]   mem_q  [NUM_SRC][DEPTH];
    logic [PW-1:0] head_q [NUM_SRC];
    logic [PW-1:0] tail_q [NUM_SRC];
    logic [CW-1:0] cnt_q  [NUM_SRC];
    logic [1:0]    last_grant_q;
    logic          cdb_valid_q;
    logic [3:0]    cdb_rob_pos_q;
    logic [31:0]   cdb_val_q;
    logic [1:0]    cdb_src_q;
    logic          overflow_q;

    logic          grant_valid_d;
    logic [1:0]    grant_idx_d;
    logic [1:0]    idx;
    logic [35:0]   grant_entry_d;
    logic [NUM_SRC-1:0] push_d;
    logic [NUM_SRC-1:0] pop_d;

    // Ready depends only on registered counts, never on this cycle's pop.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_ready[k] = (cnt_q[k] < CW'(DEPTH));
        end
    end

    always_comb begin
        grant_valid_d = 1'b0;
        grant_idx_d   = 2'd0;
        idx           = 2'd0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = 2'((int'(last_grant_q) + i) % NUM_SRC);
            if (!grant_valid_d && cnt_q[idx] != '0) begin
                grant_valid_d = 1'b1;
                grant_idx_d   = idx;
            end
        end
        grant_entry_d = mem_q[grant_idx_d][head_q[grant_idx_d]];
        for (int k = 0; k < NUM_SRC; k++) begin
            push_d[k] = src_valid[k] && src_ready[k];
            pop_d[k]  = grant_valid_d && (grant_idx_d == 2'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                head_q[k] <= '0;
                tail_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            last_grant_q  <= 2'(NUM_SRC - 1);
            cdb_valid_q   <= 1'b0;
            cdb_rob_pos_q <= 4'd0;
            cdb_val_q     <= 32'd0;
            cdb_src_q     <= 2'd0;
            overflow_q    <= 1'b0;
        end else if (rdy) begin
            if (rollback) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    head_q[k] <= '0;
                    tail_q[k] <= '0;
                    cnt_q[k]  <= '0;
                end
                last_grant_q <= 2'(NUM_SRC - 1);
                cdb_valid_q  <= 1'b0;
            end else begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (src_valid[k] && !src_ready[k]) begin
                        overflow_q <= 1'b1;
                    end
                    if (push_d[k]) begin
                        mem_q[k][tail_q[k]] <= {src_rob_pos[4*k +: 4], src_val[32*k +: 32]};
                        tail_q[k] <= tail_q[k] + PW'(1);
                    end
                    if (pop_d[k]) begin
                        head_q[k] <= head_q[k] + PW'(1);
                    end
                    if (push_d[k] && !pop_d[k]) begin
                        cnt_q[k] <= cnt_q[k] + CW'(1);
                    end else if (!push_d[k] && pop_d[k]) begin
                        cnt_q[k] <= cnt_q[k] - CW'(1);
                    end
                end
                cdb_valid_q <= grant_valid_d;
                if (grant_valid_d) begin
                    cdb_rob_pos_q <= grant_entry_d[35:32];
                    cdb_val_q     <= grant_entry_d[31:0];
                    cdb_src_q     <= grant_idx_d;
                    last_grant_q  <= grant_idx_d;
                end
            end
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_pos = cdb_rob_pos_q;
    assign cdb_val     = cdb_val_q;
    assign cdb_src     = cdb_src_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single push, round-robin stream,
// overflow, rollback, rdy freeze and back-to-back single-source broadcasts.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [2:0]  src_valid;
    logic [11:0] src_rob_pos;
    logic [95:0] src_val;
    logic [2:0]  src_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_pos;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.NUM_SRC(3), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .src_valid(src_valid), .src_rob_pos(src_rob_pos), .src_val(src_val),
        .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos),
        .cdb_val(cdb_val), .cdb_src(cdb_src), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int k, input logic [3:0] rob, input logic [31:0] val);
        src_rob_pos[4*k +: 4]  = rob;
        src_val[32*k +: 32]    = val;
    endtask

    task automatic chk_bc(input string tag, input int src, input logic [3:0] rob, input logic [31:0] val);
        chk({tag, "_valid"}, {31'd0, cdb_valid}, 32'd1);
        chk({tag, "_src"}, {30'd0, cdb_src}, src);
        chk({tag, "_rob"}, {28'd0, cdb_rob_pos}, {28'd0, rob});
        chk({tag, "_val"}, cdb_val, val);
    endtask

    task automatic do_reset();
        rst = 1'b1; src_valid = 3'b000; rollback = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    // grant schedule for the all-sources stream, -1 = no broadcast expected
    int exp_seq [12] = '{-1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, -1};
    int qr [3][$];
    int mcnt [3];
    int rp;

    initial begin
        rdy = 1'b1; rollback = 1'b0; src_valid = 3'b000;
        src_rob_pos = '0; src_val = '0;
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rst_rob", {28'd0, cdb_rob_pos}, 32'd0);
        chk("rst_val", cdb_val, 32'd0);
        chk("rst_src", {30'd0, cdb_src}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_ready", {29'd0, src_ready}, 32'd7);
        rst = 1'b0;

        // single ALU push, no bypass
        set_src(0, 4'd3, 32'h11); src_valid = 3'b001;
        cyc();
        src_valid = 3'b000;
        chk("a_nobypass", {31'd0, cdb_valid}, 32'd0);
        chk("a_ready0", {29'd0, src_ready}, 32'd7);
        cyc();
        chk_bc("a_bc", 0, 4'd3, 32'h11);
        chk("a_ready1", {29'd0, src_ready}, 32'd7);
        cyc();
        chk("a_idle", {31'd0, cdb_valid}, 32'd0);
        chk("a_hold_rob", {28'd0, cdb_rob_pos}, 32'd3);

        // all sources stream for 6 cycles, honoring ready
        do_reset();
        rp = 1;
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        for (int c = 0; c < 12; c++) begin
            logic [2:0] pv;
            pv = 3'b000;
            for (int k = 0; k < 3; k++) begin
                if (c < 6 && mcnt[k] < 2) begin
                    pv[k] = 1'b1;
                    set_src(k, 4'(rp), 32'h100 + rp);
                    qr[k].push_back(rp);
                    rp++;
                end
            end
            chk("b_ready", {29'd0, src_ready},
                {29'd0, mcnt[2] < 2, mcnt[1] < 2, mcnt[0] < 2});
            src_valid = pv;
            cyc();
            if (exp_seq[c] >= 0) begin
                int s, r;
                s = exp_seq[c];
                r = qr[s].pop_front();
                chk_bc("b_bc", s, 4'(r), 32'h100 + r);
                mcnt[s]--;
            end else begin
                chk("b_idle", {31'd0, cdb_valid}, 32'd0);
            end
            for (int k = 0; k < 3; k++) if (pv[k]) mcnt[k]++;
        end
        src_valid = 3'b000;
        chk("b_ovf", {31'd0, overflow}, 32'd0);
        chk("b_drained", qr[0].size() + qr[1].size() + qr[2].size(), 32'd0);

        // rollback with buffered entries and a simultaneous push
        do_reset();
        for (int k = 0; k < 3; k++) set_src(k, 4'(k + 1), 32'hD0 + k);
        src_valid = 3'b111;
        cyc();
        chk("d_nobc", {31'd0, cdb_valid}, 32'd0);
        for (int k = 0; k < 3; k++) set_src(k, 4'(k + 4), 32'hE0 + k);
        cyc();
        chk_bc("d_bc0", 0, 4'd1, 32'hD0);
        chk("d_ready_pre", {29'd0, src_ready}, 32'd1);
        for (int k = 0; k < 3; k++) set_src(k, 4'(k + 7), 32'hF0 + k);
        rollback = 1'b1;
        cyc();
        rollback = 1'b0; src_valid = 3'b000;
        chk("d_rb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("d_rb_ready", {29'd0, src_ready}, 32'd7);
        chk("d_rb_ovf", {31'd0, overflow}, 32'd0);
        cyc();
        chk("d_rb_empty", {31'd0, cdb_valid}, 32'd0);
        set_src(0, 4'd12, 32'h120); set_src(1, 4'd13, 32'h130);
        src_valid = 3'b011;
        cyc();
        src_valid = 3'b000;
        chk("d_nobc2", {31'd0, cdb_valid}, 32'd0);
        cyc();
        chk_bc("d_first", 0, 4'd12, 32'h120);
        cyc();
        chk_bc("d_second", 1, 4'd13, 32'h130);
        cyc();
        chk("d_done", {31'd0, cdb_valid}, 32'd0);

        // overflow on a full LSB FIFO
        do_reset();
        set_src(0, 4'd1, 32'hA0); set_src(1, 4'd4, 32'hB0);
        src_valid = 3'b011;
        cyc();
        set_src(0, 4'd2, 32'hA1); set_src(1, 4'd5, 32'hB1);
        cyc();
        chk_bc("c_a0", 0, 4'd1, 32'hA0);
        chk("c_ready", {29'd0, src_ready}, 32'd5);
        set_src(1, 4'd6, 32'hBAD);
        src_valid = 3'b010;
        cyc();
        src_valid = 3'b000;
        chk_bc("c_b0", 1, 4'd4, 32'hB0);
        chk("c_ovf_set", {31'd0, overflow}, 32'd1);
        cyc();
        chk_bc("c_a1", 0, 4'd2, 32'hA1);
        cyc();
        chk_bc("c_b1", 1, 4'd5, 32'hB1);
        cyc();
        chk("c_no_drop_bc", {31'd0, cdb_valid}, 32'd0);
        chk("c_ovf_sticky", {31'd0, overflow}, 32'd1);

        // rdy freeze mid-broadcast
        for (int k = 0; k < 3; k++) set_src(k, 4'(k + 1), 32'h50 + k);
        src_valid = 3'b111;
        cyc();
        src_valid = 3'b000;
        cyc();
        chk_bc("e_bc2", 2, 4'd3, 32'h52);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            src_valid = (c == 1) ? 3'b000 : 3'b111;
            set_src(0, 4'hF, 32'hFFFF);
            cyc();
            chk_bc("e_frozen", 2, 4'd3, 32'h52);
            chk("e_ready", {29'd0, src_ready}, 32'd7);
        end
        src_valid = 3'b000; rdy = 1'b1;
        cyc();
        chk_bc("e_resume0", 0, 4'd1, 32'h50);
        cyc();
        chk_bc("e_resume1", 1, 4'd2, 32'h51);
        cyc();
        chk("e_idle", {31'd0, cdb_valid}, 32'd0);
        chk("e_ovf", {31'd0, overflow}, 32'd1);

        // MUL back-to-back
        set_src(2, 4'd9, 32'hDEAD); src_valid = 3'b100;
        cyc();
        chk("f_nobc", {31'd0, cdb_valid}, 32'd0);
        set_src(2, 4'd10, 32'hBEEF);
        cyc();
        src_valid = 3'b000;
        chk_bc("f_first", 2, 4'd9, 32'hDEAD);
        cyc();
        chk_bc("f_second", 2, 4'd10, 32'hBEEF);
        cyc();
        chk("f_idle", {31'd0, cdb_valid}, 32'd0);

        // only rst clears overflow and the broadcast registers
        do_reset();
        chk("g_ovf_clr", {31'd0, overflow}, 32'd0);
        chk("g_val_clr", cdb_val, 32'd0);
        chk("g_src_clr", {30'd0, cdb_src}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
